// File: rtl/sys_defs.sv
// sys_defs: shared memory-bus command and size encodings plus the tag-table entry type
package sys_defs;
  localparam int XLEN = 32;
  localparam logic [1:0] BUS_NONE = 2'h0;
  localparam logic [1:0] BUS_LOAD = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;
  typedef enum logic [1:0] {BYTE = 2'h0, HALF = 2'h1, WORD = 2'h2, DOUBLE = 2'h3} MEM_SIZE;
  typedef struct packed {
    logic valid;
    logic [2:0] port;
    logic drop;
  } MEM_TAG_ENTRY;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first requester at or after ptr, wrapping; one-hot grant plus index
module rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int PORT_LEN = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_LEN-1:0]  ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PORT_LEN-1:0]  idx,
  output logic                 found
);
  logic [PORT_LEN-1:0] j;
  always_comb begin
    found = 1'b0;
    idx = '0;
    j = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      j = PORT_LEN'((int'(ptr) + k) % NUM_PORTS);
      if (!found && req[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
    gnt = found ? (NUM_PORTS'(1) << idx) : '0;
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin front end sharing one tagged memory bus among NUM_PORTS clients
module mem_bus_arbiter
  import sys_defs::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int TAG_W = 4,
  parameter int MAX_OUTST = 4,
  parameter int PORT_LEN = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [NUM_PORTS-1:0]                         req_valid,
  input  logic [NUM_PORTS-1:0][1:0]                    req_command,
  input  logic [NUM_PORTS-1:0][XLEN-1:0]               req_addr,
  input  logic [NUM_PORTS-1:0][63:0]                   req_data,
  input  logic [NUM_PORTS-1:0][1:0]                    req_size,
  input  logic [NUM_PORTS-1:0]                         squash,
  output logic [NUM_PORTS-1:0]                         req_accept,
  output logic [NUM_PORTS-1:0][TAG_W-1:0]              req_tag,
  output logic [NUM_PORTS-1:0]                         resp_valid,
  output logic [TAG_W-1:0]                             resp_tag,
  output logic [63:0]                                  resp_data,
  output logic [NUM_PORTS-1:0][$clog2(MAX_OUTST+1)-1:0] outst_count,
  output logic [1:0]                                   proc2mem_command,
  output logic [XLEN-1:0]                              proc2mem_addr,
  output logic [63:0]                                  proc2mem_data,
  output logic [1:0]                                   proc2mem_size,
  input  logic [TAG_W-1:0]                             mem2proc_response,
  input  logic [TAG_W-1:0]                             mem2proc_tag,
  input  logic [63:0]                                  mem2proc_data,
  output logic                                         unexpected_tag
);
  localparam int NT = 2 ** TAG_W;
  localparam int CW = $clog2(MAX_OUTST + 1);
  MEM_TAG_ENTRY tbl [NT];
  MEM_TAG_ENTRY ent;
  logic [PORT_LEN-1:0] rr_ptr, g;
  logic [NUM_PORTS-1:0] elig, gnt;
  logic [7:0] sq8;
  logic found, accept, ld_acc, hit, deliver;
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++)
      elig[i] = req_valid[i] && !squash[i] && !(req_command[i] == BUS_LOAD && outst_count[i] == CW'(MAX_OUTST));
  end
  rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PORT_LEN(PORT_LEN)) u_rr (
    .req(elig), .ptr(rr_ptr), .gnt(gnt), .idx(g), .found(found)
  );
  assign accept = found && mem2proc_response != '0;
  assign ld_acc = accept && req_command[g] == BUS_LOAD;
  assign req_accept = accept ? gnt : '0;
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++)
      req_tag[i] = req_accept[i] ? mem2proc_response : '0;
  end
  assign proc2mem_command = found ? req_command[g] : BUS_NONE;
  assign proc2mem_addr = found ? req_addr[g] : '0;
  assign proc2mem_data = found ? req_data[g] : '0;
  assign proc2mem_size = found ? req_size[g] : '0;
  assign sq8 = 8'(squash);
  assign ent = tbl[mem2proc_tag];
  assign hit = mem2proc_tag != '0 && ent.valid;
  // a squash landing on the same cycle as its port's return still suppresses that return
  assign deliver = hit && !ent.drop && !sq8[ent.port];
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int t = 0; t < NT; t++) tbl[t] <= '0;
      outst_count <= '0;
      rr_ptr <= '0;
      resp_valid <= '0;
      resp_tag <= '0;
      resp_data <= '0;
      unexpected_tag <= 1'b0;
    end else begin
      for (int t = 0; t < NT; t++)
        if (tbl[t].valid && sq8[tbl[t].port]) tbl[t].drop <= 1'b1;
      if (hit) tbl[mem2proc_tag] <= '0;
      // a new load on a tag returning this cycle must overwrite the cleared entry
      if (ld_acc) tbl[mem2proc_response] <= '{valid: 1'b1, port: 3'(g), drop: 1'b0};
      for (int i = 0; i < NUM_PORTS; i++)
        outst_count[i] <= outst_count[i] + CW'(ld_acc && g == PORT_LEN'(i)) - CW'(hit && ent.port == 3'(i));
      if (accept) rr_ptr <= (g == PORT_LEN'(NUM_PORTS - 1)) ? '0 : g + PORT_LEN'(1);
      resp_valid <= deliver ? (NUM_PORTS'(1) << ent.port) : '0;
      resp_tag <= deliver ? mem2proc_tag : '0;
      resp_data <= deliver ? mem2proc_data : '0;
      unexpected_tag <= unexpected_tag | (mem2proc_tag != '0 && !ent.valid);
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed plus randomized checks against a tag-ownership reference model
module tb_mem_bus_arbiter;
  import sys_defs::*;
  localparam int NP = 2, TW = 4, MO = 4, CW = 3, NT = 16;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;
  logic [NP-1:0] req_valid, squash, req_accept, resp_valid;
  logic [NP-1:0][1:0] req_command, req_size;
  logic [NP-1:0][XLEN-1:0] req_addr;
  logic [NP-1:0][63:0] req_data;
  logic [NP-1:0][TW-1:0] req_tag;
  logic [TW-1:0] resp_tag, mem2proc_response, mem2proc_tag;
  logic [63:0] resp_data, proc2mem_data, mem2proc_data;
  logic [NP-1:0][CW-1:0] outst_count;
  logic [1:0] proc2mem_command, proc2mem_size;
  logic [XLEN-1:0] proc2mem_addr;
  logic unexpected_tag;
  mem_bus_arbiter #(.NUM_PORTS(NP), .TAG_W(TW), .MAX_OUTST(MO)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_command(req_command),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size), .squash(squash),
    .req_accept(req_accept), .req_tag(req_tag), .resp_valid(resp_valid), .resp_tag(resp_tag),
    .resp_data(resp_data), .outst_count(outst_count), .proc2mem_command(proc2mem_command),
    .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
    .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag),
    .mem2proc_data(mem2proc_data), .unexpected_tag(unexpected_tag)
  );
  int compared = 0, mismatched = 0;
  int m_cnt [NP];
  int m_rr;
  int m_p [NT];
  bit m_v [NT];
  bit m_d [NT];
  bit m_unexp;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    m_rr = 0;
    m_unexp = 0;
    for (int i = 0; i < NP; i++) m_cnt[i] = 0;
    for (int t = 0; t < NT; t++) begin
      m_v[t] = 0;
      m_p[t] = 0;
      m_d[t] = 0;
    end
  endtask
  task automatic idle();
    req_valid = '0;
    squash = '0;
    req_command = '0;
    req_addr = '0;
    req_data = '0;
    req_size = '0;
    mem2proc_response = '0;
    mem2proc_tag = '0;
    mem2proc_data = '0;
  endtask
  task automatic cyc();
    int g, dp, p, rt;
    bit fnd, acc, dlv, el;
    logic [63:0] rdat;
    #1;
    fnd = 0;
    g = 0;
    for (int k = 0; k < NP; k++) begin
      p = (m_rr + k) % NP;
      el = req_valid[p] && !squash[p] && !(req_command[p] == BUS_LOAD && m_cnt[p] == MO);
      if (!fnd && el) begin
        fnd = 1;
        g = p;
      end
    end
    acc = fnd && mem2proc_response != 0;
    chk("proc2mem_command", 64'(proc2mem_command), fnd ? 64'(req_command[g]) : 64'(BUS_NONE));
    if (fnd) begin
      chk("proc2mem_addr", 64'(proc2mem_addr), 64'(req_addr[g]));
      chk("proc2mem_data", proc2mem_data, req_data[g]);
      chk("proc2mem_size", 64'(proc2mem_size), 64'(req_size[g]));
    end
    chk("req_accept", 64'(req_accept), acc ? (64'(1) << g) : 64'(0));
    if (acc) chk("req_tag", 64'(req_tag[g]), 64'(mem2proc_response));
    rt = int'(mem2proc_tag);
    rdat = mem2proc_data;
    dlv = 0;
    dp = 0;
    if (rt != 0) begin
      if (m_v[rt]) begin
        dp = m_p[rt];
        dlv = !m_d[rt] && !squash[dp];
        m_cnt[dp]--;
        m_v[rt] = 0;
      end else m_unexp = 1;
    end
    for (int t = 0; t < NT; t++) if (m_v[t] && squash[m_p[t]]) m_d[t] = 1;
    if (acc) begin
      if (req_command[g] == BUS_LOAD) begin
        m_v[mem2proc_response] = 1;
        m_p[mem2proc_response] = g;
        m_d[mem2proc_response] = 0;
        m_cnt[g]++;
      end
      m_rr = (g + 1) % NP;
    end
    @(posedge clock);
    #1;
    chk("resp_valid", 64'(resp_valid), dlv ? (64'(1) << dp) : 64'(0));
    if (dlv) begin
      chk("resp_tag", 64'(resp_tag), 64'(rt));
      chk("resp_data", resp_data, rdat);
    end
    for (int i = 0; i < NP; i++) chk("outst_count", 64'(outst_count[i]), 64'(m_cnt[i]));
    chk("unexpected_tag", 64'(unexpected_tag), 64'(m_unexp));
    @(negedge clock);
  endtask
  task automatic ld(input int p, input logic [XLEN-1:0] a, input logic [TW-1:0] t);
    idle();
    req_valid[p] = 1'b1;
    req_command[p] = BUS_LOAD;
    req_addr[p] = a;
    req_size[p] = 2'(WORD);
    mem2proc_response = t;
    cyc();
  endtask
  task automatic ret(input logic [TW-1:0] t, input logic [63:0] d);
    idle();
    mem2proc_tag = t;
    mem2proc_data = d;
    cyc();
  endtask
  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    m_reset();
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_outst", 64'(outst_count), 64'(0));
    chk("rst_unexpected", 64'(unexpected_tag), 64'(0));
    chk("rst_command", 64'(proc2mem_command), 64'(BUS_NONE));
    chk("rst_accept", 64'(req_accept), 64'(0));
    @(negedge clock);
    reset = 1'b0;
  endtask
  initial begin
    int s, t;
    reset = 1'b1;
    idle();
    m_reset();
    @(negedge clock);
    do_reset();
    ld(0, 32'h100, 4'd3);
    chk("single_outst", 64'(outst_count[0]), 64'(1));
    idle();
    repeat (9) cyc();
    ret(4'd3, 64'hDEAD_BEEF);
    chk("single_resp", resp_data, 64'hDEAD_BEEF);
    idle();
    req_valid = '1;
    req_command[0] = BUS_STORE;
    req_command[1] = BUS_STORE;
    req_addr[0] = 32'h40;
    req_addr[1] = 32'h80;
    req_data[0] = 64'h11;
    req_data[1] = 64'h22;
    mem2proc_response = 4'd1;
    repeat (4) cyc();
    mem2proc_response = 4'd0;
    repeat (2) cyc();
    mem2proc_response = 4'd2;
    repeat (3) cyc();
    ld(1, 32'h200, 4'd1);
    ld(1, 32'h204, 4'd2);
    ld(1, 32'h208, 4'd4);
    ld(1, 32'h20c, 4'd6);
    idle();
    req_valid = '1;
    req_command[0] = BUS_LOAD;
    req_command[1] = BUS_LOAD;
    mem2proc_response = 4'd8;
    cyc();
    chk("credit_port0_granted", 64'(outst_count[0]), 64'(1));
    idle();
    req_valid[1] = 1'b1;
    req_command[1] = BUS_LOAD;
    mem2proc_response = 4'd9;
    mem2proc_tag = 4'd1;
    mem2proc_data = 64'h5151;
    cyc();
    mem2proc_tag = 4'd0;
    cyc();
    chk("credit_reenabled", 64'(outst_count[1]), 64'(4));
    ret(4'd2, 64'h2);
    ret(4'd4, 64'h4);
    ret(4'd6, 64'h6);
    ret(4'd8, 64'h8);
    ret(4'd9, 64'h9);
    ld(0, 32'h300, 4'd2);
    ld(0, 32'h304, 4'd5);
    idle();
    squash[0] = 1'b1;
    cyc();
    ret(4'd2, 64'hBAD2);
    ret(4'd5, 64'hBAD5);
    chk("squash_drained", 64'(outst_count[0]), 64'(0));
    ld(0, 32'h308, 4'd2);
    ret(4'd2, 64'h1234);
    ld(1, 32'h400, 4'd7);
    idle();
    req_valid[0] = 1'b1;
    req_command[0] = BUS_LOAD;
    mem2proc_response = 4'd7;
    mem2proc_tag = 4'd7;
    mem2proc_data = 64'hAAAA;
    cyc();
    chk("reuse_port1", 64'(resp_valid), 64'(2));
    ret(4'd7, 64'hBBBB);
    chk("reuse_port0", 64'(resp_valid), 64'(1));
    ret(4'd9, 64'h0);
    idle();
    repeat (3) cyc();
    chk("unexpected_sticky", 64'(unexpected_tag), 64'(1));
    ld(0, 32'h500, 4'd4);
    do_reset();
    idle();
    cyc();
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int p = 0; p < NP; p++) begin
        req_valid[p] = $urandom_range(0, 3) != 0;
        req_command[p] = $urandom_range(0, 1) != 0 ? BUS_LOAD : BUS_STORE;
        req_addr[p] = $urandom;
        req_data[p] = {$urandom, $urandom};
        req_size[p] = 2'($urandom_range(0, 3));
        squash[p] = $urandom_range(0, 19) == 0;
      end
      if ($urandom_range(0, 2) != 0) begin
        s = $urandom_range(0, 14);
        for (int k = 0; k < 15; k++) begin
          t = 1 + (s + k) % 15;
          if (m_v[t] && mem2proc_tag == 0) mem2proc_tag = TW'(t);
        end
      end
      mem2proc_data = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) begin
        s = $urandom_range(0, 14);
        for (int k = 0; k < 15; k++) begin
          t = 1 + (s + k) % 15;
          if ((!m_v[t] || t == int'(mem2proc_tag)) && mem2proc_response == 0) mem2proc_response = TW'(t);
        end
      end
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
